// File: rtl/lock_controller.sv
// lock_controller: top-level sequencing FSM for the smart lock.
//
// Collects four hex keypad digits into a 16-bit entry, hands the entry and the
// stored password to the password checker, and acts on the result: an unlock
// hold window on a match, consecutive-failure counting and a lockout alarm on
// repeated mismatches or checker timeouts.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_key_valid    one-cycle pulse, i_key_code carries a new digit
//   i_key_code     digit value 0x0..0xF
//   i_key_enter    one-cycle pulse, submit the entry
//   i_key_clear    one-cycle pulse, discard the partial entry
//   o_chk_start    one-cycle start pulse to the checker
//   o_chk_data1    entered password, stable while the check is in flight
//   o_chk_data2    stored password, stable while the check is in flight
//   i_chk_finish   checker done, i_chk_match valid in the same cycle
//   i_chk_match    checker result
//   o_unlock       lock actuator drive
//   o_alarm        lockout indicator
//   o_busy         high while a check is being started or awaited
//   o_fail_count   current consecutive failures
//   o_pw_changed   one-cycle pulse when the stored password is updated
//
// Build option: define PW_CHANGE_EN to allow a new password to be entered
// while unlocked. Without it the stored password is the constant DEFAULT_PW.
module lock_controller #(
  parameter int unsigned UNLOCK_CYCLES  = 100,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned CHK_TIMEOUT    = 15,
  parameter logic [15:0] DEFAULT_PW     = 16'h1234
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  input  logic        i_key_enter,
  input  logic        i_key_clear,
  output logic        o_chk_start,
  output logic [15:0] o_chk_data1,
  output logic [15:0] o_chk_data2,
  input  logic        i_chk_finish,
  input  logic        i_chk_match,
  output logic        o_unlock,
  output logic        o_alarm,
  output logic        o_busy,
  output logic [1:0]  o_fail_count,
  output logic        o_pw_changed
);

  // One hold counter serves all timed states, so size it for the longest.
  localparam int unsigned CntMaxA = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned CntMax  = (CntMaxA > CHK_TIMEOUT) ? CntMaxA : CHK_TIMEOUT;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] UnlockLd  = CntW'(UNLOCK_CYCLES);
  localparam logic [CntW-1:0] LockoutLd = CntW'(LOCKOUT_CYCLES);
  localparam logic [CntW-1:0] ChkLd     = CntW'(CHK_TIMEOUT);
  localparam logic [1:0]      MaxFails  = 2'(MAX_FAILS);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheckStart,
    StCheckWait,
    StUnlocked,
    StLockout
  } state_e;

  state_e          r_state;
  logic [15:0]     r_buf;
  logic [2:0]      r_dcnt;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_fail_count;
  logic            r_chk_start;
  logic [15:0]     r_chk_data1;
  logic [15:0]     r_chk_data2;
  logic            r_unlock;
  logic            r_alarm;
  logic            r_busy;

  logic [15:0]     w_stored_pw;
  logic [15:0]     w_buf_shift;
  logic [2:0]      w_dcnt_inc;
  logic [1:0]      w_fail_inc;
  logic            w_dcnt_full;

  assign w_buf_shift = {r_buf[11:0], i_key_code};
  assign w_dcnt_inc  = r_dcnt + 3'd1;
  assign w_fail_inc  = r_fail_count + 2'd1;
  assign w_dcnt_full = (r_dcnt == 3'd4);

`ifdef PW_CHANGE_EN
  logic [15:0] r_stored_pw;
  logic        r_pw_changed;
  assign w_stored_pw  = r_stored_pw;
  assign o_pw_changed = r_pw_changed;
`else
  assign w_stored_pw  = DEFAULT_PW;
  assign o_pw_changed = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_buf        <= '0;
      r_dcnt       <= '0;
      r_cnt        <= '0;
      r_fail_count <= '0;
      r_chk_start  <= 1'b0;
      r_chk_data1  <= '0;
      r_chk_data2  <= '0;
      r_unlock     <= 1'b0;
      r_alarm      <= 1'b0;
      r_busy       <= 1'b0;
`ifdef PW_CHANGE_EN
      r_stored_pw  <= DEFAULT_PW;
      r_pw_changed <= 1'b0;
`endif
    end else begin
      r_chk_start <= 1'b0;
`ifdef PW_CHANGE_EN
      r_pw_changed <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          // A clear or enter in the same cycle outranks the digit.
          if (i_key_valid && !i_key_enter && !i_key_clear) begin
            r_buf   <= {12'h000, i_key_code};
            r_dcnt  <= 3'd1;
            r_state <= StEntry;
          end
        end

        StEntry: begin
          if (i_key_clear) begin
            r_buf   <= '0;
            r_dcnt  <= '0;
            r_state <= StIdle;
          end else if (i_key_enter) begin
            if (w_dcnt_full) begin
              r_chk_data1 <= r_buf;
              r_chk_data2 <= w_stored_pw;
              r_chk_start <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= StCheckStart;
            end else begin
              r_state <= StIdle;
            end
            r_buf  <= '0;
            r_dcnt <= '0;
          end else if (i_key_valid && !w_dcnt_full) begin
            r_buf  <= w_buf_shift;
            r_dcnt <= w_dcnt_inc;
          end
        end

        StCheckStart: begin
          r_cnt   <= ChkLd;
          r_state <= StCheckWait;
        end

        StCheckWait: begin
          if (i_chk_finish && i_chk_match) begin
            r_fail_count <= '0;
            r_unlock     <= 1'b1;
            r_cnt        <= UnlockLd;
            r_busy       <= 1'b0;
            r_state      <= StUnlocked;
          end else if (i_chk_finish || (r_cnt == CntOne)) begin
            // Explicit mismatch or timeout both count as a failed attempt.
            r_fail_count <= w_fail_inc;
            r_busy       <= 1'b0;
            if (w_fail_inc == MaxFails) begin
              r_alarm <= 1'b1;
              r_cnt   <= LockoutLd;
              r_state <= StLockout;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end

        StUnlocked: begin
`ifdef PW_CHANGE_EN
          if (i_key_enter && !i_key_clear && w_dcnt_full) begin
            r_stored_pw  <= r_buf;
            r_pw_changed <= 1'b1;
            r_unlock     <= 1'b0;
            r_buf        <= '0;
            r_dcnt       <= '0;
            r_state      <= StIdle;
          end else if (r_cnt == CntOne) begin
            // Window expired: any partial new password is discarded.
            r_unlock <= 1'b0;
            r_buf    <= '0;
            r_dcnt   <= '0;
            r_state  <= StIdle;
          end else begin
            r_cnt <= r_cnt - CntOne;
            if (i_key_clear) begin
              r_buf  <= '0;
              r_dcnt <= '0;
            end else if (i_key_valid && !i_key_enter && !w_dcnt_full) begin
              r_buf  <= w_buf_shift;
              r_dcnt <= w_dcnt_inc;
            end
          end
`else
          if (r_cnt == CntOne) begin
            r_unlock <= 1'b0;
            r_state  <= StIdle;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
`endif
        end

        StLockout: begin
          if (r_cnt == CntOne) begin
            r_alarm      <= 1'b0;
            r_fail_count <= '0;
            r_state      <= StIdle;
          end else begin
            r_cnt <= r_cnt - CntOne;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_chk_start  = r_chk_start;
  assign o_chk_data1  = r_chk_data1;
  assign o_chk_data2  = r_chk_data2;
  assign o_unlock     = r_unlock;
  assign o_alarm      = r_alarm;
  assign o_busy       = r_busy;
  assign o_fail_count = r_fail_count;

endmodule
